icache_sa_refill: RTL and testbench

- Parametrised set-associative instruction cache between the fetch stage and the instruction memory port.
- Successor to the single-configuration direct-mapped icache.
- Adds configurable sets, ways and line length, a word-serial refill handshake, round-robin replacement, whole-cache flush and saturating hit/miss counters.
- Drives the fetch-side stall that feeds the global stall.

---
 rtl/icache_sa_refill_if.sv | 27 ++
 rtl/icache_sa_refill.sv | 190 +++++++++++++++++++
 tb/tb_icache_sa_refill.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_sa_refill_if.sv
// Fetch-side lookup and word-serial refill signals shared by the icache and its environment.
// The cache side uses the master modport; the fetch stage / memory model uses slave.
interface icache_sa_refill_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_instr;
    logic              icache_stall;
    logic              flush;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  fetch_req, fetch_addr, flush, mem_ack, mem_rvalid, mem_rdata,
        output fetch_instr, icache_stall, mem_req, mem_addr
    );

    modport slave (
        output fetch_req, fetch_addr, flush, mem_ack, mem_rvalid, mem_rdata,
        input  fetch_instr, icache_stall, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_sa_refill.sv
// Set-associative instruction cache with combinational lookup, word-serial line refill,
// round-robin replacement, whole-cache flush and saturating hit/miss counters.
module icache_sa_refill #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_SETS   = 4,
    parameter int NUM_WAYS   = 2,
    parameter int COUNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    icache_sa_refill_if.master bus,
    output logic [COUNT_W-1:0] hit_count,
    output logic [COUNT_W-1:0] miss_count
);
    localparam int BYTE_BITS = $clog2(DATA_W / 8);
    localparam int WORD_BITS = $clog2(LINE_WORDS);
    localparam int OFF       = BYTE_BITS + WORD_BITS;
    localparam int SET_BITS  = $clog2(NUM_SETS);
    localparam int IDX_W     = (SET_BITS > 0) ? SET_BITS : 1;
    localparam int WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int TAG_W     = ADDR_W - OFF - SET_BITS;
    localparam int LINE_AW   = (NUM_SETS * NUM_WAYS > 1) ? $clog2(NUM_SETS * NUM_WAYS) : 1;
    localparam int LINES     = 2 ** LINE_AW;
    localparam int SETS_D    = 2 ** IDX_W;

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t                         state_reg, state_next;
    logic [ADDR_W-1:0]              line_addr_reg, line_addr_next;
    logic [WAY_W-1:0]               victim_reg, victim_next;
    logic [WORD_BITS-1:0]           beat_reg, beat_next;
    logic                           flush_pend_reg, flush_pend_next;
    logic                           just_filled_reg, just_filled_next;
    logic [LINES-1:0]               valid_reg, valid_next;
    logic [SETS_D-1:0][WAY_W-1:0]   rr_reg, rr_next;
    logic [COUNT_W-1:0]             hit_cnt_reg, hit_cnt_next;
    logic [COUNT_W-1:0]             miss_cnt_reg, miss_cnt_next;

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES * LINE_WORDS];

    logic [IDX_W-1:0]     req_set, fill_set;
    logic [TAG_W-1:0]     req_tag, fill_tag;
    logic [WORD_BITS-1:0] req_word;
    logic [NUM_WAYS-1:0]  way_valid, way_hit;
    logic [WAY_W-1:0]     hit_way, victim_sel;
    logic                 hit, last_beat;
    logic [DATA_W-1:0]    hit_data;

    // Flat line number of (set, way) in the tag/valid/data arrays.
    function automatic logic [LINE_AW-1:0] line_of(input logic [IDX_W-1:0] s,
                                                   input logic [WAY_W-1:0] w);
        return LINE_AW'(int'(s) * NUM_WAYS + int'(w));
    endfunction

    generate
        if (SET_BITS > 0) begin : g_set
            assign req_set  = bus.fetch_addr[OFF +: SET_BITS];
            assign fill_set = line_addr_reg[OFF +: SET_BITS];
        end else begin : g_noset
            assign req_set  = '0;
            assign fill_set = '0;
        end
    endgenerate

    assign req_tag  = bus.fetch_addr[ADDR_W-1 -: TAG_W];
    assign fill_tag = line_addr_reg[ADDR_W-1 -: TAG_W];
    assign req_word = bus.fetch_addr[BYTE_BITS +: WORD_BITS];

    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
            assign way_valid[gi] = valid_reg[line_of(req_set, WAY_W'(gi))];
            assign way_hit[gi]   = way_valid[gi] &&
                                   (tag_mem[line_of(req_set, WAY_W'(gi))] == req_tag);
        end
    endgenerate

    // Lowest-index hit way; victim is the lowest invalid way, else the set's pointer.
    always_comb begin
        hit_way    = '0;
        victim_sel = rr_reg[req_set];
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (way_hit[w])    hit_way    = WAY_W'(w);
            if (!way_valid[w]) victim_sel = WAY_W'(w);
        end
    end

    assign hit       = |way_hit;
    assign hit_data  = data_mem[{line_of(req_set, hit_way), req_word}];
    assign last_beat = (beat_reg == WORD_BITS'(LINE_WORDS - 1));

    assign bus.fetch_instr  = (state_reg == IDLE && bus.fetch_req && hit) ? hit_data : '0;
    assign bus.icache_stall = (state_reg != IDLE) || (bus.fetch_req && (!hit || bus.flush));
    assign bus.mem_req      = (state_reg == REQ);
    assign bus.mem_addr     = line_addr_reg;
    assign hit_count        = hit_cnt_reg;
    assign miss_count       = miss_cnt_reg;

    always_comb begin
        state_next       = state_reg;
        line_addr_next   = line_addr_reg;
        victim_next      = victim_reg;
        beat_next        = beat_reg;
        flush_pend_next  = flush_pend_reg;
        just_filled_next = 1'b0;
        valid_next       = valid_reg;
        rr_next          = rr_reg;
        hit_cnt_next     = hit_cnt_reg;
        miss_cnt_next    = miss_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.flush) begin
                    valid_next = '0;
                end else if (bus.fetch_req) begin
                    if (hit) begin
                        if (!just_filled_reg && hit_cnt_reg != '1)
                            hit_cnt_next = hit_cnt_reg + COUNT_W'(1);
                    end else begin
                        line_addr_next  = {bus.fetch_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
                        victim_next     = victim_sel;
                        beat_next       = '0;
                        flush_pend_next = 1'b0;
                        if (miss_cnt_reg != '1)
                            miss_cnt_next = miss_cnt_reg + COUNT_W'(1);
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.flush)   flush_pend_next = 1'b1;
                if (bus.mem_ack) state_next      = FILL;
            end
            FILL: begin
                if (bus.flush) flush_pend_next = 1'b1;
                if (bus.mem_rvalid) begin
                    beat_next = beat_reg + WORD_BITS'(1);
                    if (last_beat) begin
                        // A flush seen during the refill also kills the line just written.
                        if (flush_pend_reg || bus.flush)
                            valid_next = '0;
                        else
                            valid_next[line_of(fill_set, victim_reg)] = 1'b1;
                        rr_next[fill_set] = WAY_W'((int'(rr_reg[fill_set]) + 1) % NUM_WAYS);
                        flush_pend_next   = 1'b0;
                        just_filled_next  = 1'b1;
                        state_next        = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            line_addr_reg   <= '0;
            victim_reg      <= '0;
            beat_reg        <= '0;
            flush_pend_reg  <= 1'b0;
            just_filled_reg <= 1'b0;
            valid_reg       <= '0;
            rr_reg          <= '0;
            hit_cnt_reg     <= '0;
            miss_cnt_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            line_addr_reg   <= line_addr_next;
            victim_reg      <= victim_next;
            beat_reg        <= beat_next;
            flush_pend_reg  <= flush_pend_next;
            just_filled_reg <= just_filled_next;
            valid_reg       <= valid_next;
            rr_reg          <= rr_next;
            hit_cnt_reg     <= hit_cnt_next;
            miss_cnt_reg    <= miss_cnt_next;
        end
    end

    // Tag and data storage carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (state_reg == FILL && bus.mem_rvalid) begin
            data_mem[{line_of(fill_set, victim_reg), beat_reg}] <= bus.mem_rdata;
            if (last_beat)
                tag_mem[line_of(fill_set, victim_reg)] <= fill_tag;
        end
    end
endmodule

// File: tb/tb_icache_sa_refill.sv
// Scenario bench for icache_sa_refill: a cycle-driven memory responder serves refills,
// expected instructions are queued at issue and popped when the cache serves them.
module tb_icache_sa_refill;
    localparam int LW = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] hit_count;
    logic [3:0] miss_count;
    logic [15:0] mem_gen = 16'h0000;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb_q[$];

    icache_sa_refill_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    icache_sa_refill #(
        .ADDR_W(32), .DATA_W(32), .LINE_WORDS(LW), .NUM_SETS(4), .NUM_WAYS(2), .COUNT_W(4)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .bus(bus),
        .hit_count(hit_count),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: generation tag in the upper half, 0xA0 + word number below.
    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [15:0] lo;
        lo = 16'h00A0 + a[17:2];
        return {mem_gen, lo};
    endfunction

    task automatic drive_idle();
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.flush      = 1'b0;
        bus.mem_ack    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        drive_idle();
        #1;
    endtask

    task automatic check_counts(input string name, input logic [3:0] exp_hit,
                                input logic [3:0] exp_miss);
        checks++;
        if (hit_count !== exp_hit) begin
            errors++;
            $display("FAIL %s hit_count: got %0d want %0d", name, hit_count, exp_hit);
        end
        checks++;
        if (miss_count !== exp_miss) begin
            errors++;
            $display("FAIL %s miss_count: got %0d want %0d", name, miss_count, exp_miss);
        end
    endtask

    // Holds a fetch until served, acting as memory for any refill it triggers.
    task automatic run_fetch(input logic [31:0] addr, input int ack_dly, input int gap,
                             input int flush_at, input int exp_stalls, input string name);
        logic [31:0] line;
        logic [31:0] exp;
        int stalls, req_cycles, beat, gap_cnt;
        bit acked, done;
        line = addr & 32'hFFFF_FFF0;
        sb_q.push_back(model_word(addr));
        stalls = 0; req_cycles = 0; beat = 0; gap_cnt = 0; acked = 0; done = 0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            bus.fetch_req  = 1'b1;
            bus.fetch_addr = addr;
            bus.flush      = (cyc == flush_at);
            bus.mem_ack    = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (bus.mem_req) begin
                checks++;
                if (bus.mem_addr !== line) begin
                    errors++;
                    $display("FAIL %s mem_addr: got %h want %h", name, bus.mem_addr, line);
                end
                if (req_cycles == ack_dly) begin
                    bus.mem_ack = 1'b1;
                    acked = 1;
                end
                req_cycles++;
            end else if (acked) begin
                if (gap_cnt < gap) begin
                    gap_cnt++;
                end else begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = model_word(line + 32'(4 * beat));
                    beat++;
                    gap_cnt = 0;
                    if (beat == LW) begin
                        acked = 0; req_cycles = 0; beat = 0;
                    end
                end
            end
            #1;
            if (!bus.icache_stall) begin
                exp = sb_q.pop_front();
                checks++;
                if (bus.fetch_instr !== exp) begin
                    errors++;
                    $display("FAIL %s instr @%h: got %h want %h", name, addr, bus.fetch_instr, exp);
                end
                done = 1;
            end else begin
                stalls++;
            end
        end
        if (!done) begin
            errors++;
            checks++;
            void'(sb_q.pop_front());
            $display("FAIL %s timeout @%h: still stalled, want served", name, addr);
        end
        checks++;
        if (stalls != exp_stalls) begin
            errors++;
            $display("FAIL %s stall cycles @%h: got %0d want %0d", name, addr, stalls, exp_stalls);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        @(negedge clk);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset mem_req: got %b want 0", bus.mem_req); end
        checks++;
        if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset mem_addr: got %h want 0", bus.mem_addr); end
        checks++;
        if (bus.fetch_instr !== 32'h0) begin errors++; $display("FAIL reset fetch_instr: got %h want 0", bus.fetch_instr); end
        checks++;
        if (bus.icache_stall !== 1'b1) begin errors++; $display("FAIL reset stall: got %b want 1", bus.icache_stall); end
        check_counts("reset", 4'd0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.fetch_req = 1'b0;
        #1;
        checks++;
        if (bus.icache_stall !== 1'b0) begin errors++; $display("FAIL idle stall: got %b want 0", bus.icache_stall); end
        $display("test_reset done");
    endtask

    task automatic test_cold_miss();
        apply_reset();
        mem_gen = 16'h0000;
        run_fetch(32'h00, 0, 0, -1, 1 + 1 + LW, "cold_miss");
        run_fetch(32'h04, 0, 0, -1, 0, "cold_hit1");
        run_fetch(32'h08, 0, 0, -1, 0, "cold_hit2");
        run_fetch(32'h0C, 0, 0, -1, 0, "cold_hit3");
        idle_cycle();
        check_counts("cold", 4'd3, 4'd1);
        $display("test_cold_miss done");
    endtask

    task automatic test_replacement();
        apply_reset();
        mem_gen = 16'h0001;
        run_fetch(32'h00, 0, 0, -1, 6, "repl_fill00");
        run_fetch(32'h40, 0, 0, -1, 6, "repl_fill40");
        run_fetch(32'h80, 0, 0, -1, 6, "repl_fill80");
        run_fetch(32'h44, 0, 0, -1, 0, "repl_hit40");
        run_fetch(32'h00, 0, 0, -1, 6, "repl_miss00");
        idle_cycle();
        check_counts("repl", 4'd1, 4'd4);
        run_fetch(32'h84, 0, 0, -1, 0, "repl_hit80");
        run_fetch(32'h48, 0, 0, -1, 6, "repl_miss40");
        $display("test_replacement done");
    endtask

    task automatic test_slow_handshake();
        apply_reset();
        mem_gen = 16'h0002;
        run_fetch(32'h24, 6, 2, -1, 1 + 7 + 3 * LW, "slow_miss");
        run_fetch(32'h20, 0, 0, -1, 0, "slow_w0");
        run_fetch(32'h28, 0, 0, -1, 0, "slow_w2");
        run_fetch(32'h2C, 0, 0, -1, 0, "slow_w3");
        $display("test_slow_handshake done");
    endtask

    task automatic test_flush_idle();
        apply_reset();
        mem_gen = 16'h0003;
        run_fetch(32'h00, 0, 0, -1, 6, "fli_fill");
        @(negedge clk);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h00;
        bus.flush      = 1'b1;
        #1;
        checks++;
        if (bus.icache_stall !== 1'b1) begin errors++; $display("FAIL fli flush stall: got %b want 1", bus.icache_stall); end
        idle_cycle();
        checks++;
        if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL fli no refill: mem_req got %b want 0", bus.mem_req); end
        check_counts("fli_flushcycle", 4'd0, 4'd1);
        mem_gen = 16'h0004;
        run_fetch(32'h00, 0, 0, -1, 6, "fli_refetch");
        idle_cycle();
        check_counts("fli", 4'd0, 4'd2);
        $display("test_flush_idle done");
    endtask

    task automatic test_flush_fill();
        apply_reset();
        mem_gen = 16'h0005;
        run_fetch(32'h00, 0, 0, -1, 6, "flf_fill00");
        run_fetch(32'h10, 0, 0, 3, 12, "flf_fill10");
        idle_cycle();
        check_counts("flf", 4'd0, 4'd3);
        run_fetch(32'h04, 0, 0, -1, 6, "flf_stale00");
        idle_cycle();
        check_counts("flf_end", 4'd0, 4'd4);
        $display("test_flush_fill done");
    endtask

    task automatic test_reset_mid_fill();
        apply_reset();
        mem_gen = 16'h0006;
        @(negedge clk);
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 32'h30;
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rmf mem_req: got %b want 1", bus.mem_req); end
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = model_word(32'h30);
        @(negedge clk);
        bus.mem_rdata  = model_word(32'h34);
        @(negedge clk);
        check_counts("rmf_before", 4'd0, 4'd1);
        drive_idle();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rmf reset mem_req: got %b want 0", bus.mem_req); end
        check_counts("rmf_reset", 4'd0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'hDEAD_0000 + 32'(i);
            #1;
            checks++;
            if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rmf stray beat %0d mem_req: got %b want 0", i, bus.mem_req); end
        end
        idle_cycle();
        run_fetch(32'h38, 0, 0, -1, 6, "rmf_refetch");
        idle_cycle();
        check_counts("rmf_end", 4'd0, 4'd1);
        $display("test_reset_mid_fill done");
    endtask

    task automatic test_saturation();
        logic [31:0] a;
        apply_reset();
        mem_gen = 16'h0007;
        run_fetch(32'h00, 0, 0, -1, 6, "sat_fill");
        for (int i = 0; i < 15; i++) begin
            a = 32'(4 * (i % 4));
            run_fetch(a, 0, 0, -1, 0, "sat_hit");
        end
        idle_cycle();
        check_counts("sat15", 4'd15, 4'd1);
        for (int i = 0; i < 5; i++) begin
            a = 32'(4 * (i % 4));
            run_fetch(a, 0, 0, -1, 0, "sat_hit");
        end
        idle_cycle();
        check_counts("sat20", 4'd15, 4'd1);
        $display("test_saturation done");
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_replacement();
        test_slow_handshake();
        test_flush_idle();
        test_flush_fill();
        test_reset_mid_fill();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
